// File: rtl/channel_arbiter.sv
// channel_arbiter: shares one NBITS_DATA-wide display channel between two
// requesters (A and B). A Moore FSM grants one requester at a time, bounds
// the hold time to HOLD_MAX cycles while the other side is waiting, and
// counts grant entries per requester.
// Optional feature macro: CHANNEL_ARB_RR_EN
//   defined   -> a tie in IDLE goes to the requester that was not served last
//   undefined -> a tie in IDLE always goes to A
module channel_arbiter #(
   parameter int NBITS_DATA = 2,
   parameter int HOLD_MAX   = 4,
   parameter int NBITS_CNT  = 8
) (
   input  logic                  clk_2,
   input  logic                  rst_n,
   input  logic                  req_a,
   input  logic [NBITS_DATA-1:0] data_a,
   input  logic                  req_b,
   input  logic [NBITS_DATA-1:0] data_b,
   output logic                  gnt_a,
   output logic                  gnt_b,
   output logic                  ch_valid,
   output logic                  ch_src,
   output logic [NBITS_DATA-1:0] ch_data,
   output logic [NBITS_CNT-1:0]  cnt_a,
   output logic [NBITS_CNT-1:0]  cnt_b
);

   localparam int HOLD_W = $clog2(HOLD_MAX + 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT_A = 2'd1,
      GRANT_B = 2'd2
   } state_t;

   state_t              state_reg, state_next;
   logic                last_reg, last_next;        // 0 = A served last, 1 = B
   logic [HOLD_W-1:0]   hold_cnt_reg, hold_cnt_next;
   logic                hold_done;
   logic                tie_to_a;
   logic [1:0]          entry;                      // [0] = entering A, [1] = entering B

   assign hold_done = (hold_cnt_reg == HOLD_W'(HOLD_MAX));

`ifdef CHANNEL_ARB_RR_EN
   // Round-robin: B served last (or reset) means A wins the tie.
   assign tie_to_a = last_reg;
`else
   // Fixed priority: A always wins an idle tie.
   assign tie_to_a = 1'b1;
`endif

   assign entry[0] = (state_next == GRANT_A) && (state_reg != GRANT_A);
   assign entry[1] = (state_next == GRANT_B) && (state_reg != GRANT_B);

   // State, last-served pointer and hold counter registers
   always_ff @(posedge clk_2 or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= IDLE;
         last_reg     <= 1'b1;
         hold_cnt_reg <= '0;
      end else begin
         state_reg    <= state_next;
         last_reg     <= last_next;
         hold_cnt_reg <= hold_cnt_next;
      end
   end

   // Next-state decision: handoff on release, preemption at hold limit
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (req_a && req_b)
               state_next = tie_to_a ? GRANT_A : GRANT_B;
            else if (req_a)
               state_next = GRANT_A;
            else if (req_b)
               state_next = GRANT_B;
         end
         GRANT_A: begin
            if (!req_a)
               state_next = req_b ? GRANT_B : IDLE;
            else if (req_b && hold_done)
               state_next = GRANT_B;
         end
         GRANT_B: begin
            if (!req_b)
               state_next = req_a ? GRANT_A : IDLE;
            else if (req_a && hold_done)
               state_next = GRANT_A;
         end
         default: state_next = IDLE;
      endcase
   end

   // Hold counter and last-served bookkeeping for the upcoming state
   always_comb begin
      hold_cnt_next = hold_cnt_reg;
      last_next     = last_reg;
      if (state_next == IDLE)
         hold_cnt_next = '0;
      else if (entry != 2'b00)
         hold_cnt_next = HOLD_W'(1);
      else if (!hold_done)
         hold_cnt_next = hold_cnt_reg + HOLD_W'(1);
      if (entry[0])
         last_next = 1'b0;
      else if (entry[1])
         last_next = 1'b1;
   end

   // Per-requester grant counters, bumped on every grant entry, wrapping
   for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
      logic [NBITS_CNT-1:0] cnt_reg;
      // Count entries into this requester's grant state
      always_ff @(posedge clk_2 or negedge rst_n) begin
         if (!rst_n)
            cnt_reg <= '0;
         else if (entry[gi])
            cnt_reg <= cnt_reg + NBITS_CNT'(1);
      end
   end

   assign cnt_a = g_cnt[0].cnt_reg;
   assign cnt_b = g_cnt[1].cnt_reg;

   // Moore grant decode and unregistered channel data mux
   always_comb begin
      gnt_a    = (state_reg == GRANT_A);
      gnt_b    = (state_reg == GRANT_B);
      ch_valid = gnt_a | gnt_b;
      ch_src   = gnt_b;
      ch_data  = '0;
      if (gnt_a)
         ch_data = data_a;
      else if (gnt_b)
         ch_data = data_b;
   end

endmodule

// File: tb/tb_channel_arbiter.sv
// tb_channel_arbiter: scoreboard bench for channel_arbiter. Each driven cycle
// pushes the expected output word into a queue; after the clock edge the word
// is popped and compared with the DUT outputs. Honors CHANNEL_ARB_RR_EN.
module tb_channel_arbiter;

   localparam int NBITS_DATA = 2;
   localparam int HOLD_MAX   = 4;
   localparam int NBITS_CNT  = 8;

   logic                  clk_2 = 1'b0;
   logic                  rst_n;
   logic                  req_a, req_b;
   logic [NBITS_DATA-1:0] data_a, data_b;
   logic                  gnt_a, gnt_b, ch_valid, ch_src;
   logic [NBITS_DATA-1:0] ch_data;
   logic [NBITS_CNT-1:0]  cnt_a, cnt_b;

   int total = 0;
   int bad   = 0;

   // Model state: 0 idle, 1 A, 2 B; last 0 = A, 1 = B
   int m_st, m_last, m_hold, m_ca, m_cb;
   logic [21:0] exp_q[$];

   channel_arbiter #(
      .NBITS_DATA(NBITS_DATA),
      .HOLD_MAX  (HOLD_MAX),
      .NBITS_CNT (NBITS_CNT)
   ) dut (
      .clk_2   (clk_2),
      .rst_n   (rst_n),
      .req_a   (req_a),
      .data_a  (data_a),
      .req_b   (req_b),
      .data_b  (data_b),
      .gnt_a   (gnt_a),
      .gnt_b   (gnt_b),
      .ch_valid(ch_valid),
      .ch_src  (ch_src),
      .ch_data (ch_data),
      .cnt_a   (cnt_a),
      .cnt_b   (cnt_b)
   );

   always #5 clk_2 = ~clk_2;

   function automatic logic [21:0] obs();
      return {gnt_a, gnt_b, ch_valid, ch_src, ch_data, cnt_a, cnt_b};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end else begin
         $display("ok   %s: %0h", tag, got);
      end
   endtask

   task automatic model_reset();
      m_st = 0; m_last = 1; m_hold = 0; m_ca = 0; m_cb = 0;
   endtask

   // Advance the reference model one cycle and push the expected outputs
   task automatic model_step(input logic ra, input logic [1:0] da,
                             input logic rb, input logic [1:0] db);
      int ns;
      logic ga, gb;
      logic [1:0] d;
      ns = m_st;
      if (m_st == 0) begin
         if (ra && rb) begin
`ifdef CHANNEL_ARB_RR_EN
            ns = (m_last == 1) ? 1 : 2;
`else
            ns = 1;
`endif
         end else if (ra) ns = 1;
         else if (rb) ns = 2;
      end else if (m_st == 1) begin
         if (!ra) ns = rb ? 2 : 0;
         else if (rb && m_hold == HOLD_MAX) ns = 2;
      end else begin
         if (!rb) ns = ra ? 1 : 0;
         else if (ra && m_hold == HOLD_MAX) ns = 1;
      end
      if (ns == 0) m_hold = 0;
      else if (ns != m_st) begin
         m_hold = 1;
         m_last = ns - 1;
         if (ns == 1) m_ca = (m_ca + 1) % 256;
         else         m_cb = (m_cb + 1) % 256;
      end else if (m_hold < HOLD_MAX) m_hold++;
      m_st = ns;
      ga = (m_st == 1);
      gb = (m_st == 2);
      d  = ga ? da : (gb ? db : 2'b00);
      exp_q.push_back({ga, gb, ga | gb, gb, d, 8'(m_ca), 8'(m_cb)});
   endtask

   // Drive one cycle of stimulus, then compare after the edge
   task automatic drive(input string tag, input logic ra, input logic [1:0] da,
                        input logic rb, input logic [1:0] db);
      logic [21:0] e;
      req_a = ra; data_a = da; req_b = rb; data_b = db;
      model_step(ra, da, rb, db);
      @(posedge clk_2);
      #1;
      e = exp_q.pop_front();
      check(tag, 32'(obs()), 32'(e));
   endtask

   // Reset between edges and release it away from the clock edge
   task automatic do_reset();
      req_a = 0; req_b = 0; data_a = 0; data_b = 0;
      rst_n = 1'b0;
      model_reset();
      @(negedge clk_2);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; req_a = 0; req_b = 0; data_a = 0; data_b = 0;
      model_reset();
      repeat (2) @(posedge clk_2);
      #1;
      check("reset_outputs", 32'(obs()), 32'h0);
      @(negedge clk_2);
      rst_n = 1'b1;

      // Single requester A for three cycles, then release
      for (int i = 0; i < 3; i++) drive("a_only", 1, 2'b10, 0, 2'b00);
      check("a_only_src", 32'(ch_src), 32'h0);
      drive("a_release", 0, 2'b10, 0, 2'b00);
      check("a_release_cnt_a", 32'(cnt_a), 32'd1);
      check("a_release_idle", 32'(ch_valid), 32'h0);

      // Both requesting continuously: preemption every HOLD_MAX cycles
      do_reset();
      for (int i = 0; i < 24; i++) drive("both_held", 1, 2'b01, 1, 2'b11);
      check("both_cnt_a", 32'(cnt_a), 32'd3);
      check("both_cnt_b", 32'(cnt_b), 32'd3);

      // Tie from idle, release, fresh tie
      do_reset();
      drive("tie1", 1, 2'b01, 1, 2'b10);
      check("tie1_winner_a", 32'(gnt_a), 32'h1);
      drive("tie_rel", 0, 2'b01, 0, 2'b10);
      drive("tie2", 1, 2'b01, 1, 2'b10);
`ifdef CHANNEL_ARB_RR_EN
      check("tie2_winner_b", 32'(gnt_b), 32'h1);
`else
      check("tie2_winner_a", 32'(gnt_a), 32'h1);
`endif
      drive("tie_rel2", 0, 2'b01, 0, 2'b10);

      // Direct handoff A -> B with no idle cycle
      drive("ho_a", 1, 2'b11, 0, 2'b01);
      drive("ho_a", 1, 2'b11, 0, 2'b01);
      drive("ho_b", 0, 2'b11, 1, 2'b01);
      check("handoff_valid", 32'(ch_valid), 32'h1);
      check("handoff_src", 32'(ch_src), 32'h1);
      drive("ho_hold_b", 0, 2'b11, 1, 2'b01);
      drive("ho_back_a", 1, 2'b10, 0, 2'b01);

      // Asynchronous reset in the middle of a grant
      drive("pre_rst", 1, 2'b10, 0, 2'b00);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check("async_rst_outputs", 32'(obs()), 32'h0);
      @(negedge clk_2);
      req_a = 0;
      rst_n = 1'b1;
      drive("post_rst_b", 0, 2'b00, 1, 2'b01);
      check("post_rst_gnt_b", 32'(gnt_b), 32'h1);
      check("post_rst_cnt_b", 32'(cnt_b), 32'd1);
      drive("post_rst_rel", 0, 2'b00, 0, 2'b01);

      // Counter wrap: 256 separate grants to A
      do_reset();
      for (int i = 0; i < 256; i++) begin
         drive("wrap_on", 1, 2'(i), 0, 2'b00);
         drive("wrap_off", 0, 2'(i), 0, 2'b00);
         if (i == 254) check("wrap_cnt_255", 32'(cnt_a), 32'd255);
      end
      check("wrap_cnt_a", 32'(cnt_a), 32'd0);
      check("wrap_cnt_b", 32'(cnt_b), 32'd0);

      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
